// File: rtl/tbm_xfer_sequencer.sv
// rtl/tbm_xfer_sequencer.sv - in-order 4 KB page transfer sequencer with command FIFO
//
// Purpose: queues page-transfer commands and issues them one at a time to the
// transfer buffer's TBM-side port, waiting for xfer_complete or a timeout and
// producing a one-cycle completion record for each command.
//
// Ports:
//   clock_fpga      - clock, rising edge
//   reset           - asynchronous active-low reset
//   cmd_valid/ready - command handshake; cmd_ready = (cmd_count < CMDQ_DEPTH)
//   cmd_write       - 1 = transfer buffer -> TBM, 0 = TBM -> transfer buffer
//   cmd_address     - TBM byte address (low 12 bits dropped, flagged if nonzero)
//   cmd_count       - queued entries
//   rx_avail        - gate for write commands
//   tx_space        - gate for read commands
//   xfer_buf_select - one-cycle issue strobe
//   mwrite_enable   - direction of the issued command (held until next issue)
//   tbm_address     - page address of the issued command (held until next issue)
//   xfer_complete   - page done from the transfer buffer (honoured only in WAIT)
//   busy            - sequencer not idle
//   done_*          - completion record, done_valid pulses for one cycle
module tbm_xfer_sequencer #(
   parameter int CMDQ_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int ADDRESS_WIDTH  = 32
) (
   input  logic                     clock_fpga,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_write,
   input  logic [ADDRESS_WIDTH-1:0] cmd_address,
   output logic [2:0]               cmd_count,
   input  logic                     rx_avail,
   input  logic                     tx_space,
   output logic                     xfer_buf_select,
   output logic                     mwrite_enable,
   output logic [ADDRESS_WIDTH-1:0] tbm_address,
   input  logic                     xfer_complete,
   output logic                     busy,
   output logic                     done_valid,
   output logic                     done_write,
   output logic [ADDRESS_WIDTH-1:0] done_address,
   output logic                     done_timeout,
   output logic                     done_misaligned
);

   localparam int PW  = (CMDQ_DEPTH > 1) ? $clog2(CMDQ_DEPTH) : 1;
   localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int PAW = ADDRESS_WIDTH - 12;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   // Command FIFO: only the page number is stored, plus the misaligned flag.
   logic           r_q_write [CMDQ_DEPTH];
   logic [PAW-1:0] r_q_page  [CMDQ_DEPTH];
   logic           r_q_mis   [CMDQ_DEPTH];
   logic [PW-1:0]  r_head;
   logic [PW-1:0]  r_tail;
   logic [2:0]     r_count;

   state_t                   r_state;
   logic [TW-1:0]            r_timer;
   logic                     r_cur_mis;
   logic                     r_xfer_buf_select;
   logic                     r_mwrite_enable;
   logic [ADDRESS_WIDTH-1:0] r_tbm_address;
   logic                     r_done_valid;
   logic                     r_done_write;
   logic [ADDRESS_WIDTH-1:0] r_done_address;
   logic                     r_done_timeout;
   logic                     r_done_misaligned;

   logic w_push;
   logic w_pop;
   logic w_head_write;
   logic w_gate;

   assign cmd_ready    = (r_count < 3'(CMDQ_DEPTH));
   assign w_push       = cmd_valid & cmd_ready;
   // The head entry leaves the queue during the ISSUE cycle.
   assign w_pop        = (r_state == S_ISSUE);
   assign w_head_write = r_q_write[r_head];
   // Strict in-order: only the head's own gate matters.
   assign w_gate       = w_head_write ? rx_avail : tx_space;

   always_ff @(posedge clock_fpga) begin
      if (w_push) begin
         r_q_write[r_tail] <= cmd_write;
         r_q_page[r_tail]  <= cmd_address[ADDRESS_WIDTH-1:12];
         r_q_mis[r_tail]   <= (cmd_address[11:0] != 12'h000);
      end
   end

   always_ff @(posedge clock_fpga or negedge reset) begin
      if (!reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop)  r_head <= r_head + 1'b1;
         r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
      end
   end

   always_ff @(posedge clock_fpga or negedge reset) begin
      if (!reset) begin
         r_state           <= S_IDLE;
         r_timer           <= '0;
         r_cur_mis         <= 1'b0;
         r_xfer_buf_select <= 1'b0;
         r_mwrite_enable   <= 1'b0;
         r_tbm_address     <= '0;
         r_done_valid      <= 1'b0;
         r_done_write      <= 1'b0;
         r_done_address    <= '0;
         r_done_timeout    <= 1'b0;
         r_done_misaligned <= 1'b0;
      end else begin
         r_xfer_buf_select <= 1'b0;
         r_done_valid      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_count != 3'd0 && w_gate) begin
                  r_state           <= S_ISSUE;
                  r_xfer_buf_select <= 1'b1;
                  r_mwrite_enable   <= w_head_write;
                  r_tbm_address     <= {r_q_page[r_head], 12'h000};
                  r_cur_mis         <= r_q_mis[r_head];
               end
            end
            S_ISSUE: begin
               r_timer <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // Completion takes priority over an expiry in the same cycle.
               if (xfer_complete || r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                  r_state           <= S_DONE;
                  r_done_valid      <= 1'b1;
                  r_done_write      <= r_mwrite_enable;
                  r_done_address    <= r_tbm_address;
                  r_done_misaligned <= r_cur_mis;
                  r_done_timeout    <= ~xfer_complete;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_count       = r_count;
   assign busy            = (r_state != S_IDLE);
   assign xfer_buf_select = r_xfer_buf_select;
   assign mwrite_enable   = r_mwrite_enable;
   assign tbm_address     = r_tbm_address;
   assign done_valid      = r_done_valid;
   assign done_write      = r_done_write;
   assign done_address    = r_done_address;
   assign done_timeout    = r_done_timeout;
   assign done_misaligned = r_done_misaligned;

endmodule

// File: doc/tbm_xfer_sequencer.md
# tbm_xfer_sequencer

- Sequences 4 KB page transfers between the transfer buffer's bottom half and TBM memory, on the clock_fpga domain.
- Queues page-transfer commands from the firmware/command decoder in a small FIFO. Each command is written (transfer buffer → TBM) or read (TBM → transfer buffer).
- Issues one command at a time to the transfer buffer via xfer_buf_select / mwrite_enable / tbm_address, then waits for xfer_complete or a timeout and reports a completion record.
- Sits directly upstream of the transfer buffer's TBM-side port.

## Interface
Parameters:
- CMDQ_DEPTH, 4: command FIFO entries (power of two).
- TIMEOUT_CYCLES, 4096: clock_fpga cycles allowed from issue to xfer_complete.
- ADDRESS_WIDTH, 32: TBM byte-address width.

Ports:
- clock_fpga  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO can accept; equals (cmd_count < CMDQ_DEPTH).
- cmd_write  input  1  1 = write page to TBM, 0 = read page from TBM.
- cmd_address  input  ADDRESS_WIDTH  TBM byte address of page.
- cmd_count  output  3  entries currently queued (0..CMDQ_DEPTH).
- rx_avail  input  1  transfer buffer holds ≥1 full rx page (gates writes).
- tx_space  input  1  transfer buffer has ≥1 free tx page (gates reads).
- xfer_buf_select  output  1  one-cycle issue strobe to the transfer buffer.
- mwrite_enable  output  1  direction for the issued command; held through WAIT.
- tbm_address  output  ADDRESS_WIDTH  page address for the issued command; held through WAIT.
- xfer_complete  input  1  transfer buffer signals page done.
- busy  output  1  state ≠ IDLE.
- done_valid  output  1  one-cycle completion pulse.
- done_write  output  1  direction of the completed command.
- done_address  output  ADDRESS_WIDTH  page address of the completed command.
- done_timeout  output  1  completion was due to timeout.
- done_misaligned  output  1  the command's cmd_address[11:0] was nonzero.

## Operation
- **FIFO push:** on cmd_valid & cmd_ready, store {cmd_write, cmd_address[AW-1:12], misaligned flag}. The low 12 address bits are replaced by zero.
- **FIFO pointers:** head and tail wrap modulo CMDQ_DEPTH.
- **Simultaneous push and pop:** allowed; cmd_count is unchanged.
- **Full FIFO:** a push offered when full is not accepted, because cmd_ready = 0.
- **FSM states:** IDLE, ISSUE, WAIT, DONE.
- **IDLE:** if cmd_count ≠ 0 and the head entry's gate is true (rx_avail for write, tx_space for read), go to ISSUE. Otherwise stay. Strict in-order processing: a blocked head also blocks the entries behind it.
- **ISSUE:** for exactly one cycle, xfer_buf_select = 1 and mwrite_enable / tbm_address are driven from the head entry. Pop the entry, load timer = 0, go to WAIT.
- **WAIT:** timer increments each cycle.
  - xfer_complete = 1 → go to DONE with timeout = 0.
  - Otherwise, timer == TIMEOUT_CYCLES-1 → go to DONE with timeout = 1.
  - If xfer_complete and expiry fall in the same cycle, completion wins (timeout = 0).
- **DONE:** done_valid = 1 for one cycle with the latched done_* fields, then go to IDLE.
- **xfer_complete outside WAIT:** ignored, including in the ISSUE cycle.
- **Register timing:** mwrite_enable and tbm_address stay at the issued values until the next ISSUE. done_* fields other than done_valid hold until the next DONE.
- **Timer width:** log2(TIMEOUT_CYCLES)+1 bits; it never wraps.

## Timing
- **Reset values:** all outputs 0, except cmd_ready = 1. Also state = IDLE, FIFO empty, timer = 0.
- **Reset mid-transfer:** reset asserted at any point, including WAIT, aborts immediately. All queued commands are discarded and no done_valid is produced.
- **Latency from empty/IDLE with the gate true:**
  - Command accepted at edge N; xfer_buf_select is high in cycle N+2.
  - xfer_complete sampled high at edge M; done_valid is high in cycle M+1.
  - The next ISSUE is no earlier than 2 cycles after done_valid (DONE → IDLE → ISSUE).
- **Minimum command-to-command spacing:** ISSUE, WAIT ≥ 1, DONE, IDLE, i.e. 4 cycles.
- **Gate timing:** the gate is sampled only in IDLE. Deassertion after ISSUE has no effect.

## Test plan
- **Single write:** after reset, push write at 0x0000_3000 with rx_avail = 1.
  - xfer_buf_select pulses 2 cycles later with mwrite_enable = 1 and tbm_address = 0x3000.
  - Complete after 128 cycles → done_valid with done_write = 1, timeout = 0, misaligned = 0.
- **Full queue:** push 5 commands back-to-back with gates low.
  - cmd_ready drops after 4 accepts and cmd_count = 4.
  - Raise tx_space → 4 reads issue in order, and cmd_ready returns to 1 after the first pop.
- **Blocked head:** head is a write with rx_avail = 0 and the second entry is a read with tx_space = 1.
  - No issue occurs until rx_avail = 1.
  - Then the write issues before the read.
- **Timeout:** TIMEOUT_CYCLES = 16 and xfer_complete is never asserted.
  - done_valid comes exactly 16 cycles after the ISSUE cycle plus 1, with done_timeout = 1.
  - Then a tie case: assert xfer_complete in the expiry cycle → done_timeout = 0.
- **Misaligned address:** push 0x0000_1234.
  - tbm_address = 0x0000_1000 and done_misaligned = 1.
- **Reset mid-WAIT:** with 3 commands queued, drop reset during WAIT.
  - All outputs return to reset values and cmd_count = 0.
  - No done_valid after reset release, and a stray xfer_complete is ignored.
